// File: rtl/zmod_txpll_ctrl.sv
// zmod_txpll_ctrl: power-up and lock sequencer for the ZMOD TX PLL.
// Drives PLL RST/PWRDWN, synchronises LOCKED, requires a stable-lock window,
// then releases the TX datapath reset. Retries on lock timeout, restarts on
// lock loss, and latches a fault once the retry budget is spent.
// Runs on the free-running 100 MHz reference, never on a PLL output.
// Optional build macro ZMOD_TXPLL_CTRL_LOSSCNT_EN adds the saturating
// lock_loss_cnt[15:0] output (RUN-to-RESET lock-loss events, cleared by rstn only).

module zmod_txpll_ctrl #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
    parameter int unsigned MAX_RETRY        = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        pll_pwrdwn,
    output logic        tx_rst_n,
    output logic        ready,
    output logic        fault,
    output logic [3:0]  retry_cnt
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int unsigned MAX_ALL = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int          TW      = $clog2(MAX_ALL + 1);

    // Last timer value of each timed phase; the timer is zero on the first cycle of a state.
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_cnt_q, retry_cnt_d;
    logic          locked_meta_q, locked_meta_d;
    logic          locked_s_q, locked_s_d;
    logic          pll_rst_q, pll_rst_d;
    logic          pll_pwrdwn_q, pll_pwrdwn_d;
    logic          tx_rst_n_q, tx_rst_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
    logic [15:0]   loss_cnt_q, loss_cnt_d;
`endif

    // Next state, retry bookkeeping and lock-loss counting; enable=0 beats everything.
    always_comb begin
        state_d       = state_q;
        retry_cnt_d   = retry_cnt_q;
        locked_meta_d = pll_locked;
        locked_s_d    = locked_meta_q;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
        loss_cnt_d    = loss_cnt_q;
`endif
        if (!enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d     = ST_RESET;
                    retry_cnt_d = 4'd0;
                end
                ST_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        if (retry_cnt_q < RETRY_LIMIT) begin
                            retry_cnt_d = retry_cnt_q + 4'd1;
                            state_d     = ST_RESET;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        retry_cnt_d = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_d = ST_RESET;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
                        if (loss_cnt_q != 16'hFFFF) begin
                            loss_cnt_d = loss_cnt_q + 16'd1;
                        end
`endif
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Phase timer: zero on every state entry, counts only in the timed states.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == ST_RESET || state_q == ST_WAIT_LOCK || state_q == ST_STABLE)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Output values decoded from the next state so every output is a flop.
    always_comb begin
        pll_pwrdwn_d = (state_d == ST_OFF) || (state_d == ST_FAULT);
        pll_rst_d    = (state_d == ST_OFF) || (state_d == ST_RESET) || (state_d == ST_FAULT);
        tx_rst_n_d   = (state_d == ST_RUN);
        ready_d      = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    // All sequential state, including the two-flop LOCKED synchroniser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_OFF;
            timer_q       <= '0;
            retry_cnt_q   <= 4'd0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            pll_pwrdwn_q  <= 1'b1;
            tx_rst_n_q    <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
            loss_cnt_q    <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_cnt_q   <= retry_cnt_d;
            locked_meta_q <= locked_meta_d;
            locked_s_q    <= locked_s_d;
            pll_rst_q     <= pll_rst_d;
            pll_pwrdwn_q  <= pll_pwrdwn_d;
            tx_rst_n_q    <= tx_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
            loss_cnt_q    <= loss_cnt_d;
`endif
        end
    end

    assign pll_rst    = pll_rst_q;
    assign pll_pwrdwn = pll_pwrdwn_q;
    assign tx_rst_n   = tx_rst_n_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retry_cnt  = retry_cnt_q;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_zmod_txpll_ctrl.sv
// tb_zmod_txpll_ctrl: scenario tasks for the TX PLL sequencer.
// Expected values are queued as stimulus is applied and popped when the DUT
// shows the corresponding behaviour. Inputs change and outputs are sampled
// 1 ns after each rising edge.

module tb_zmod_txpll_ctrl;

    localparam int RST_PULSE = 4;
    localparam int STABLE    = 8;
    localparam int TIMEOUT   = 20;
    localparam int MAXR      = 2;

    localparam int SEL_RST    = 0;
    localparam int SEL_PWRDWN = 1;
    localparam int SEL_READY  = 2;
    localparam int SEL_FAULT  = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        pll_locked;
    logic        pll_rst;
    logic        pll_pwrdwn;
    logic        tx_rst_n;
    logic        ready;
    logic        fault;
    logic [3:0]  retry_cnt;
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    typedef struct {
        string name;
        int    value;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // 100 MHz reference clock
    always #5 clk = ~clk;

    zmod_txpll_ctrl #(
        .RST_PULSE_CYC   (RST_PULSE),
        .LOCK_STABLE_CYC (STABLE),
        .LOCK_TIMEOUT_CYC(TIMEOUT),
        .MAX_RETRY       (MAXR)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .pll_pwrdwn(pll_pwrdwn),
        .tx_rst_n  (tx_rst_n),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input int v);
        exp_t t;
        t.name  = n;
        t.value = v;
        sb_q.push_back(t);
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            SEL_RST:    return pll_rst;
            SEL_PWRDWN: return pll_pwrdwn;
            SEL_READY:  return ready;
            SEL_FAULT:  return fault;
            default:    return 1'bx;
        endcase
    endfunction

    // Ticks until the selected output equals val, at most max_cyc ticks.
    task automatic wait_level(input int sel, input logic val, input int max_cyc,
                              output int cyc, output bit ok);
        cyc = 0;
        while (sig_of(sel) !== val && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        ok = (sig_of(sel) === val);
    endtask

    task automatic apply_reset();
        enable     = 1'b0;
        pll_locked = 1'b0;
        rstn       = 1'b1;
        #1;
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] obs;
        apply_reset();
        rstn = 1'b0;
        push("reset_outputs", 'h180);
        #2;
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
        tick();
        rstn = 1'b1;
        push("off_idle_outputs", 'h180);
        repeat (4) tick();
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
    endtask

    task automatic test_nominal();
        exp_t        e;
        logic [31:0] obs;
        int          cyc;
        bit          ok;
        apply_reset();
        enable = 1'b1;
        push("nom_pwrdwn_release", 1);
        wait_level(SEL_PWRDWN, 1'b0, 10, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
        push("nom_rst_pulse_len", RST_PULSE);
        cyc = 0;
        while (pll_rst === 1'b1 && cyc < 20) begin cyc++; tick(); end
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        repeat (9) tick();
        pll_locked = 1'b1;
        push("nom_lock_to_ready", 2 + STABLE + 1);
        wait_level(SEL_READY, 1'b1, 40, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        push("nom_run_outputs", 'h060);
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
        push("nom_run_hold", 'h060);
        repeat (5) tick();
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
    endtask

    task automatic test_timeout_retry();
        exp_t e;
        int   cyc;
        bit   ok;
        apply_reset();
        enable = 1'b1;
        push("retry_first_wait", 1);
        wait_level(SEL_RST, 1'b0, 20, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
        push("retry_timeout_len", TIMEOUT);
        wait_level(SEL_RST, 1'b1, 40, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        push("retry_cnt_second", 1);
        e = sb_q.pop_front(); tests_run++;
        if (32'(retry_cnt) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, retry_cnt, e.value); end
        push("retry_pulse2_len", RST_PULSE);
        cyc = 0;
        while (pll_rst === 1'b1 && cyc < 20) begin cyc++; tick(); end
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        pll_locked = 1'b1;
        push("retry_run_reached", 1);
        wait_level(SEL_READY, 1'b1, 40, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
        push("retry_cnt_cleared", 0);
        e = sb_q.pop_front(); tests_run++;
        if (32'(retry_cnt) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, retry_cnt, e.value); end
    endtask

    task automatic test_fault();
        exp_t        e;
        logic [31:0] obs;
        int          cyc;
        bit          ok;
        apply_reset();
        enable = 1'b1;
        for (int k = 0; k <= MAXR; k++) begin
            push($sformatf("fault_wait_entry%0d", k), 1);
            wait_level(SEL_RST, 1'b0, 20, cyc, ok);
            e = sb_q.pop_front(); tests_run++;
            if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
            push($sformatf("fault_attempt_retry%0d", k), k);
            e = sb_q.pop_front(); tests_run++;
            if (32'(retry_cnt) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, retry_cnt, e.value); end
            push($sformatf("fault_attempt_timeout%0d", k), TIMEOUT);
            wait_level(SEL_RST, 1'b1, 40, cyc, ok);
            e = sb_q.pop_front(); tests_run++;
            if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        end
        push("fault_outputs", 'h192);
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
        push("fault_latched", 1);
        repeat (5) tick();
        e = sb_q.pop_front(); tests_run++;
        if (32'(fault) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, fault, e.value); end
        enable = 1'b0;
        push("fault_clear_to_off", 'h18);
        tick();
        obs = {27'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
    endtask

    task automatic test_stability_glitch();
        exp_t e;
        int   cyc;
        bit   ok;
        bit   early_ready;
        bit   rst_seen;
        apply_reset();
        enable = 1'b1;
        wait_level(SEL_RST, 1'b0, 20, cyc, ok);
        push("glitch_wait_entry", 1);
        e = sb_q.pop_front(); tests_run++;
        if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
        early_ready = 1'b0;
        rst_seen    = 1'b0;
        pll_locked  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready !== 1'b0) early_ready = 1'b1;
            if (pll_rst !== 1'b0) rst_seen = 1'b1;
        end
        pll_locked = 1'b0;
        tick();
        if (ready !== 1'b0) early_ready = 1'b1;
        pll_locked = 1'b1;
        push("glitch_relock_to_ready", 2 + STABLE + 1);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (pll_rst !== 1'b0) rst_seen = 1'b1;
        end
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        push("glitch_no_early_ready", 0);
        e = sb_q.pop_front(); tests_run++;
        if (32'(early_ready) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, early_ready, e.value); end
        push("glitch_no_pll_reset", 0);
        e = sb_q.pop_front(); tests_run++;
        if (32'(rst_seen) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, rst_seen, e.value); end
        push("glitch_retry_unchanged", 0);
        e = sb_q.pop_front(); tests_run++;
        if (32'(retry_cnt) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, retry_cnt, e.value); end
    endtask

    task automatic test_lock_loss();
        exp_t        e;
        logic [31:0] obs;
        int          cyc;
        bit          ok;
        apply_reset();
        enable = 1'b1;
        wait_level(SEL_RST, 1'b0, 20, cyc, ok);
        pll_locked = 1'b1;
        push("loss_run_reached", 1);
        wait_level(SEL_READY, 1'b1, 40, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (32'(ok) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, ok, e.value); end
        repeat (3) tick();
        pll_locked = 1'b0;
        push("loss_ready_fall_delay", 3);
        wait_level(SEL_READY, 1'b0, 10, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        push("loss_outputs", 'h100);
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
        push("loss_rst_pulse_len", RST_PULSE);
        cyc = 0;
        while (pll_rst === 1'b1 && cyc < 20) begin cyc++; tick(); end
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
`ifdef ZMOD_TXPLL_CTRL_LOSSCNT_EN
        push("loss_count", 1);
        e = sb_q.pop_front(); tests_run++;
        if (32'(lock_loss_cnt) !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.value); end
`endif
    endtask

    task automatic test_async_reset();
        exp_t        e;
        logic [31:0] obs;
        int          cyc;
        bit          ok;
        apply_reset();
        enable = 1'b1;
        wait_level(SEL_RST, 1'b0, 20, cyc, ok);
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        push("async_reset_outputs", 'h180);
        #1;
        obs = {23'd0, pll_rst, pll_pwrdwn, tx_rst_n, ready, fault, retry_cnt};
        e = sb_q.pop_front(); tests_run++;
        if (obs !== 32'(e.value)) begin tests_failed++; $display("[TB] FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.value); end
        tick();
        rstn = 1'b1;
        push("async_restart_pulse_len", RST_PULSE);
        wait_level(SEL_PWRDWN, 1'b0, 10, cyc, ok);
        cyc = 0;
        while (pll_rst === 1'b1 && cyc < 20) begin cyc++; tick(); end
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
        repeat (9) tick();
        pll_locked = 1'b1;
        push("async_restart_ready", 2 + STABLE + 1);
        wait_level(SEL_READY, 1'b1, 40, cyc, ok);
        e = sb_q.pop_front(); tests_run++;
        if (cyc !== e.value) begin tests_failed++; $display("[TB] FAIL %s: got %0d want %0d", e.name, cyc, e.value); end
    endtask

    // Scenario sequence and summary
    initial begin
        rstn       = 1'b1;
        enable     = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_timeout_retry();
        test_fault();
        test_stability_glitch();
        test_lock_loss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit in case a scenario stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "[TB] time limit");
    end

endmodule
